// File: rtl/sram_arbiter.sv
// Shares the board SRAM between the VGA scan-out reader (priority) and a FIFO-buffered
// renderer write stream; every SRAM pin is driven from a register.
module sram_arbiter #(
  parameter int WFIFO_DEPTH   = 4,
  parameter int MAX_RD_STREAK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [17:0] rd_addr,
  output logic        rd_ack,
  output logic [5:0]  rd_data,
  output logic        rd_valid,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [17:0] wr_addr,
  input  logic [5:0]  wr_data,
  output logic [17:0] mem_addr,
  inout  wire  [5:0]  mem_data,
  output logic        mem_wen,
  output logic        mem_lbn,
  output logic        sram_csn,
  output logic        sram_oen,
  output logic        busy
);

  localparam int PW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, TA} state_t;

  state_t state, next_state;

  logic [17:0]   fifo_addr [WFIFO_DEPTH];
  logic [5:0]    fifo_data [WFIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [3:0]    streak;
  logic          fifo_empty, push, pop;
  logic          grant_rd, grant_wr;
  logic          drive_en;
  logic [5:0]    data_out;

  assign fifo_empty = (count == '0);
  assign wr_ready   = (count < (PW+1)'(WFIFO_DEPTH));
  assign push       = wr_valid && wr_ready;
  assign pop        = grant_wr;
  assign rd_ack     = grant_rd;
  assign busy       = (state != IDLE);
  assign mem_data   = drive_en ? data_out : 'z;

  always_comb begin
    next_state = state;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (rd_req && (fifo_empty || int'(streak) < MAX_RD_STREAK)) begin
            grant_rd   = 1'b1;
            next_state = RD1;
          end else if (!fifo_empty) begin
            grant_wr   = 1'b1;
            next_state = WR1;
          end
        end
      end
      RD1:     next_state = RD2;
      RD2:     next_state = IDLE;
      WR1:     next_state = WR2;
      WR2:     next_state = TA;
      TA:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Only reads that overtake a waiting write count toward forcing that write out.
  always_ff @(posedge clk) begin
    if (rst || fifo_empty || grant_wr) begin
      streak <= '0;
    end else if (grant_rd && streak != 4'hF) begin
      streak <= streak + 4'd1;
    end
  end

  // Pins are loaded from the state being entered, so they are valid for that whole state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_addr <= '0;
      mem_wen  <= 1'b1;
      mem_lbn  <= 1'b1;
      sram_csn <= 1'b1;
      sram_oen <= 1'b1;
      drive_en <= 1'b0;
      data_out <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= next_state;
      rd_valid <= (state == RD2);
      if (state == RD2) rd_data <= mem_data;
      case (next_state)
        RD1: begin
          mem_addr <= rd_addr;
          sram_csn <= 1'b0;
          mem_lbn  <= 1'b0;
          sram_oen <= 1'b0;
          mem_wen  <= 1'b1;
          drive_en <= 1'b0;
        end
        RD2: begin
        end
        WR1: begin
          mem_addr <= fifo_addr[rd_ptr];
          data_out <= fifo_data[rd_ptr];
          drive_en <= 1'b1;
          sram_csn <= 1'b0;
          mem_lbn  <= 1'b0;
          mem_wen  <= 1'b0;
          sram_oen <= 1'b1;
        end
        WR2: begin
          mem_wen <= 1'b1;
        end
        default: begin
          sram_csn <= 1'b1;
          mem_lbn  <= 1'b1;
          mem_wen  <= 1'b1;
          sram_oen <= 1'b1;
          drive_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small SRAM model, write logger and bus monitor.
// A released bus floats to 6'h3F through pullups, which is how high-Z is observed.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [17:0] rd_addr;
  logic        rd_ack;
  logic [5:0]  rd_data;
  logic        rd_valid;
  logic        wr_valid;
  logic        wr_ready;
  logic [17:0] wr_addr;
  logic [5:0]  wr_data;
  logic [17:0] mem_addr;
  wire  [5:0]  mem_data;
  logic        mem_wen;
  logic        mem_lbn;
  logic        sram_csn;
  logic        sram_oen;
  logic        busy;

  logic [5:0]  sram_arr [1024];
  logic [23:0] wlog [$];
  int          bus_errs = 0;
  int          total = 0;
  int          passed = 0;
  int          acks;
  logic        seen;

  sram_arbiter #(.WFIFO_DEPTH(4), .MAX_RD_STREAK(8)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wen(mem_wen), .mem_lbn(mem_lbn),
    .sram_csn(sram_csn), .sram_oen(sram_oen), .busy(busy)
  );

  always #10 clk = ~clk;

  for (genvar g = 0; g < 6; g++) begin : g_pull
    pullup (mem_data[g]);
  end

  assign mem_data = (!sram_csn && !sram_oen && mem_wen) ? sram_arr[mem_addr[9:0]] : 6'bz;

  // SRAM write strobe: capture what is on the pins during WR1.
  always @(posedge clk) begin
    if (!rst && !sram_csn && !mem_wen && mem_lbn == 1'b0) begin
      wlog.push_back({mem_addr, mem_data});
      sram_arr[mem_addr[9:0]] = mem_data;
    end
  end

  always @(negedge clk) begin
    if (!rst && !sram_csn && !sram_oen) begin
      if (!mem_wen || mem_data !== sram_arr[mem_addr[9:0]]) bus_errs++;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic req, input logic [17:0] raddr, input logic wv,
                               input logic [17:0] waddr, input logic [5:0] wdata);
    @(posedge clk);
    #1;
    rd_req   = req;
    rd_addr  = raddr;
    wr_valid = wv;
    wr_addr  = waddr;
    wr_data  = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sram_arr[i] = 6'h00;
    sram_arr[10'h345] = 6'h2A;
    rst = 1'b1;
    rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);

    // Reset state
    @(negedge clk);
    checkOutput("rst_wen", mem_wen, 1);
    checkOutput("rst_lbn", mem_lbn, 1);
    checkOutput("rst_csn", sram_csn, 1);
    checkOutput("rst_oen", sram_oen, 1);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_data_hiz", mem_data, 6'h3F);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_wr_ready", wr_ready, 1);

    // Single read
    applyStimulus(1'b1, 18'h12345, 1'b0, 18'h0, 6'h0);
    @(negedge clk);
    checkOutput("rd_ack_n", rd_ack, 1);
    checkOutput("rd_busy_n", busy, 0);
    applyStimulus(1'b0, 18'h0, 1'b0, 18'h0, 6'h0);
    @(negedge clk);
    checkOutput("rd_addr_n1", mem_addr, 18'h12345);
    checkOutput("rd_oen_n1", sram_oen, 0);
    checkOutput("rd_csn_n1", sram_csn, 0);
    checkOutput("rd_valid_n1", rd_valid, 0);
    @(negedge clk);
    checkOutput("rd_oen_n2", sram_oen, 0);
    checkOutput("rd_bus_n2", mem_data, 6'h2A);
    @(negedge clk);
    checkOutput("rd_valid_n3", rd_valid, 1);
    checkOutput("rd_data_n3", rd_data, 6'h2A);
    checkOutput("rd_oen_n3", sram_oen, 1);
    @(negedge clk);
    checkOutput("rd_valid_n4", rd_valid, 0);

    // Reset asserted while in WR1
    applyStimulus(1'b0, 18'h0, 1'b1, 18'h00010, 6'h15);
    applyStimulus(1'b0, 18'h0, 1'b0, 18'h0, 6'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("wr1_wen", mem_wen, 0);
    checkOutput("wr1_addr", mem_addr, 18'h00010);
    checkOutput("wr1_data", mem_data, 6'h15);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_wen", mem_wen, 1);
    checkOutput("abort_csn", sram_csn, 1);
    checkOutput("abort_data_hiz", mem_data, 6'h3F);
    checkOutput("abort_wr_ready", wr_ready, 1);
    checkOutput("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    checkOutput("abort_fifo_empty", busy, 0);
    wlog.delete();

    // FIFO fill while reads keep the SRAM busy
    applyStimulus(1'b1, 18'h00001, 1'b1, 18'h00100, 6'h01);
    @(negedge clk);
    checkOutput("fill_ready_0", wr_ready, 1);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b1, 18'h00001, 1'b1, 18'h00100 + 18'(i), 6'h01 + 6'(i));
      @(negedge clk);
      checkOutput("fill_ready_n", wr_ready, 1);
    end
    applyStimulus(1'b1, 18'h00001, 1'b1, 18'h00104, 6'h05);
    @(negedge clk);
    checkOutput("fill_full", wr_ready, 0);
    applyStimulus(1'b0, 18'h00001, 1'b1, 18'h00104, 6'h05);
    @(negedge clk);
    checkOutput("fill_5th_held", wr_ready, 0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (wr_ready) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("fill_5th_accepted", seen, 1);
    applyStimulus(1'b0, 18'h0, 1'b0, 18'h0, 6'h0);
    for (int c = 0; c < 100 && wlog.size() < 5; c++) @(negedge clk);
    checkOutput("fill_log_size", wlog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("fill_order", (i < wlog.size()) ? wlog[i] : 24'hFFFFFF,
                  {18'h00100 + 18'(i), 6'h01 + 6'(i)});
    end
    repeat (4) @(posedge clk);

    // Starvation guard and write-to-read turnaround
    wlog.delete();
    applyStimulus(1'b0, 18'h0, 1'b1, 18'h2ABCD, 6'h0C);
    applyStimulus(1'b1, 18'h00002, 1'b0, 18'h0, 6'h0);
    acks = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rd_ack) acks++;
      if (!mem_wen && !sram_csn) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("starve_write_seen", seen, 1);
    checkOutput("starve_reads_before_write", acks, 8);
    checkOutput("starve_wr1_addr", mem_addr, 18'h2ABCD);
    @(negedge clk);
    checkOutput("starve_wr2_wen", mem_wen, 1);
    checkOutput("starve_wr2_data", mem_data, 6'h0C);
    checkOutput("starve_wr2_oen", sram_oen, 1);
    @(negedge clk);
    checkOutput("ta_busy", busy, 1);
    checkOutput("ta_oen", sram_oen, 1);
    checkOutput("ta_csn", sram_csn, 1);
    checkOutput("ta_data_hiz", mem_data, 6'h3F);
    @(negedge clk);
    checkOutput("resume_ack", rd_ack, 1);
    @(negedge clk);
    checkOutput("resume_oen", sram_oen, 0);
    checkOutput("resume_addr", mem_addr, 18'h00002);
    applyStimulus(1'b0, 18'h0, 1'b0, 18'h0, 6'h0);
    repeat (4) @(posedge clk);

    // Push and pop together at count 3, across the pointer wrap
    wlog.delete();
    applyStimulus(1'b1, 18'h00003, 1'b1, 18'h00200, 6'h11);
    @(negedge clk);
    checkOutput("wrap_read_ack", rd_ack, 1);
    applyStimulus(1'b0, 18'h0, 1'b1, 18'h00201, 6'h12);
    applyStimulus(1'b0, 18'h0, 1'b1, 18'h00202, 6'h13);
    applyStimulus(1'b0, 18'h0, 1'b1, 18'h00203, 6'h14);
    @(negedge clk);
    checkOutput("wrap_idle_ready", wr_ready, 1);
    applyStimulus(1'b0, 18'h0, 1'b1, 18'h00204, 6'h15);
    @(negedge clk);
    checkOutput("pushpop_count3_ready", wr_ready, 1);
    checkOutput("pushpop_head_addr", mem_addr, 18'h00200);
    checkOutput("pushpop_head_data", mem_data, 6'h11);
    applyStimulus(1'b0, 18'h0, 1'b0, 18'h0, 6'h0);
    @(negedge clk);
    checkOutput("pushpop_then_full", wr_ready, 0);
    for (int c = 0; c < 100 && wlog.size() < 5; c++) @(negedge clk);
    checkOutput("wrap_log_size", wlog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("wrap_order", (i < wlog.size()) ? wlog[i] : 24'hFFFFFF,
                  {18'h00200 + 18'(i), 6'h11 + 6'(i)});
    end
    repeat (4) @(posedge clk);

    checkOutput("bus_contention", bus_errs, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
